seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Multi-cycle sequencer for the Y86 datapath. Steps one instruction at a time through fetch, decode, execute, memory, write-back and PC update, pulsing the load enable of each stage register and running the instruction- and data-memory request/acknowledge handshakes. Maintains the processor status code and stops the machine on halt, invalid instruction or memory error. Sits beside the fetch/decode/execute stages and owns every stage enable and the PC write.

## Interface

Parameters:
- `TIMEOUT`, 16: maximum wait cycles for a memory ack; 0 disables the timeout.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `icode_i` in 4: icode from the fetch register, valid while in DECODE.
- `imem_req_o` out 1: instruction-memory request.
- `imem_ack_i` in 1: instruction-memory acknowledge.
- `imem_err_i` in 1: instruction address error, qualified by `imem_ack_i`.
- `dmem_req_o` out 1: data-memory request.
- `dmem_we_o` out 1: data-memory write, valid with `dmem_req_o`.
- `dmem_ack_i` in 1: data-memory acknowledge.
- `dmem_err_i` in 1: data address error, qualified by `dmem_ack_i`.
- `f_en_o`, `d_en_o`, `e_en_o`, `m_en_o`, `w_en_o`, `pc_en_o` out 1 each: stage load enables.
- `stat_o` out 3: 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- `state_o` out 3: current state, for debug.
- `cycle_cnt_o` out CNT_W: cycles spent outside STOP.
- `instr_cnt_o` out CNT_W: number of retired instructions.

## Operation

- States and encodings: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, PCUPD = 5, STOP = 6.
- **FETCH**
  - `imem_req_o` = 1 until ack.
  - On ack without error: `f_en_o` = 1 in that cycle, next state DECODE.
  - On ack with `imem_err_i`: stat ADR, next state STOP, `f_en_o` = 0.
- **DECODE**
  - `d_en_o` = 1; `icode_i` is latched into an internal `icode_q`.
  - icode > 0xB: stat INS, next STOP.
  - icode 0 (HALT): stat HLT, next STOP.
  - Otherwise next EXECUTE.
- **EXECUTE**: `e_en_o` = 1, next MEMORY.
- **MEMORY**
  - Memory-access icodes are RMMOVL (4), MRMOVL (5), CALL (8), RET (9), PUSHL (A) and POPL (B). For these, `dmem_req_o` = 1 until ack.
  - `dmem_we_o` = 1 for RMMOVL, CALL and PUSHL; 0 otherwise.
  - Ack without error: `m_en_o` = 1, next WRITEBACK.
  - Ack with error: stat ADR, next STOP.
  - Any other icode: no request, `m_en_o` = 1, next WRITEBACK after one cycle.
- **WRITEBACK**: `w_en_o` = 1, next PCUPD.
- **PCUPD**: `pc_en_o` = 1, `instr_cnt` +1, next FETCH.
- **STOP**
  - All enables and requests are 0; `stat_o` holds.
  - Only `rst` exits this state.
- **Timeout**
  - A wait counter runs in FETCH and MEMORY while a request is pending.
  - When it reaches TIMEOUT with no ack: stat ADR, next STOP.
  - An ack in the same cycle as the limit wins, and the access completes normally.
- **Counters**
  - `cycle_cnt` increments every cycle the state is not STOP.
  - Both counters wrap modulo 2^CNT_W.
- **Reset**
  - Reset values: state FETCH, stat AOK, `icode_q` = 1 (NOP), both counters 0, wait counter 0.
  - Because outputs decode from state, `imem_req_o` = 1 in the first cycle after reset. Every other output is 0 unless qualified by an ack.
  - A reset mid-handshake drops the request at the reset edge. A late ack seen in FETCH after reset is accepted as a fresh fetch, so the memory side must not return stale acks.

## Timing

- Moore outputs: `imem_req_o`, `dmem_req_o`, `dmem_we_o`, `d_en_o`, `e_en_o`, `w_en_o`, `pc_en_o`.
- Combinational ack-qualified outputs: `f_en_o`, and `m_en_o` for access icodes.
- Minimum latency, with acks arriving in the first request cycle: 6 cycles per instruction.
  - Each memory wait cycle adds 1.
  - HALT and INS reach STOP 2 cycles after the fetch ack.
- No combinational path from `icode_i` to any output.
- `stat_o` updates at the edge that enters STOP.

## Structure

- A shared package holds:
  - icode constants 0x0–0xB (HALT, NOP, CMOVXX, IRMOVL, RMMOVL, MRMOVL, OPL, JXX, CALL, RET, PUSHL, POPL);
  - stat codes;
  - state encodings.
- One sub-module, `mem_wait`, is shared by FETCH and MEMORY: request-pending wait counter with TIMEOUT compare and ack/timeout resolution.

## Test plan

- NOP (icode 1), acks immediate → states 0,1,2,3,4,5,0; enables pulse once each in order; `instr_cnt` = 1 and `cycle_cnt` = 6 at the return to FETCH.
- PUSHL (A), dmem ack delayed 3 cycles → `dmem_req_o` and `dmem_we_o` high 4 cycles; `m_en_o` only in the ack cycle; 9 cycles total.
- icode 0xC → `stat_o` = 4 and state 6 after DECODE; no `e_en_o` or `pc_en_o`; counters frozen.
- HALT → `stat_o` = 2, STOP, `pc_en_o` never asserted; `rst` → stat 1, state 0, `imem_req_o` = 1.
- MRMOVL with TIMEOUT = 4 and no ack → ADR after 4 wait cycles; a second run with ack in the 4th wait cycle completes normally.
- `rst` asserted during a MEMORY wait → next cycle state 0, `dmem_req_o` = 0, counters 0.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the Y86 multi-cycle sequencer: icodes, status codes and state encodings.
package seq_ctrl_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVL = 4'h3;
  localparam logic [3:0] ICODE_RMMOVL = 4'h4;
  localparam logic [3:0] ICODE_MRMOVL = 4'h5;
  localparam logic [3:0] ICODE_OPL    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHL  = 4'hA;
  localparam logic [3:0] ICODE_POPL   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StPcupd     = 3'd5,
    StStop      = 3'd6
  } state_e;

  function automatic logic icode_valid(input logic [3:0] icode);
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_CMOVXX, ICODE_IRMOVL,
      ICODE_RMMOVL, ICODE_MRMOVL, ICODE_OPL, ICODE_JXX,
      ICODE_CALL, ICODE_RET, ICODE_PUSHL, ICODE_POPL: icode_valid = 1'b1;
      default:                                        icode_valid = 1'b0;
    endcase
  endfunction

  function automatic logic icode_mem(input logic [3:0] icode);
    case (icode)
      ICODE_RMMOVL, ICODE_MRMOVL, ICODE_CALL,
      ICODE_RET, ICODE_PUSHL, ICODE_POPL: icode_mem = 1'b1;
      default:                            icode_mem = 1'b0;
    endcase
  endfunction

  function automatic logic icode_wr(input logic [3:0] icode);
    case (icode)
      ICODE_RMMOVL, ICODE_CALL, ICODE_PUSHL: icode_wr = 1'b1;
      default:                               icode_wr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_ctrl_mem_wait.sv
// Request-pending wait counter shared by the instruction and data handshakes.
// Resolves each request cycle into done (clean ack), fail (error ack or timeout) or keep waiting.
module seq_ctrl_mem_wait #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic ack_i,
  input  logic err_i,
  output logic done_o,
  output logic fail_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_limit;

  // r_cnt holds the number of request cycles already spent waiting, so the
  // TIMEOUT-th request cycle is the last one; an ack in that cycle still wins.
  assign w_limit = (TIMEOUT != 0) && (r_cnt == CntW'(TIMEOUT - 1));
  assign done_o  = req_i & ack_i & ~err_i;
  assign fail_o  = req_i & ((ack_i & err_i) | (~ack_i & w_limit));

  always_ff @(posedge clk) begin
    if (rst || !req_i || ack_i || fail_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle Y86 sequencer: walks each instruction through the six stages, runs the memory
// handshakes, keeps the status code and halts the machine on HLT/ADR/INS.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  input  logic             imem_err_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  input  logic             dmem_err_i,
  output logic             f_en_o,
  output logic             d_en_o,
  output logic             e_en_o,
  output logic             m_en_o,
  output logic             w_en_o,
  output logic             pc_en_o,
  output logic [2:0]       stat_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_e           r_state;
  logic [2:0]       r_stat;
  logic [3:0]       r_icode;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  logic w_in_fetch, w_in_mem, w_mem_op;
  logic w_req, w_ack, w_err, w_done, w_fail;

  assign w_in_fetch = (r_state == StFetch);
  assign w_in_mem   = (r_state == StMemory);
  assign w_mem_op   = icode_mem(r_icode);

  assign imem_req_o = w_in_fetch;
  assign dmem_req_o = w_in_mem & w_mem_op;
  assign dmem_we_o  = w_in_mem & icode_wr(r_icode);
  assign d_en_o     = (r_state == StDecode);
  assign e_en_o     = (r_state == StExecute);
  assign w_en_o     = (r_state == StWriteback);
  assign pc_en_o    = (r_state == StPcupd);
  assign f_en_o     = w_in_fetch & w_done;
  assign m_en_o     = w_in_mem & (w_mem_op ? w_done : 1'b1);

  assign stat_o      = r_stat;
  assign state_o     = r_state;
  assign cycle_cnt_o = r_cycle_cnt;
  assign instr_cnt_o = r_instr_cnt;

  // FETCH and MEMORY never overlap, so one wait counter serves both handshakes.
  assign w_req = imem_req_o | dmem_req_o;
  assign w_ack = w_in_fetch ? imem_ack_i : dmem_ack_i;
  assign w_err = w_in_fetch ? imem_err_i : dmem_err_i;

  seq_ctrl_mem_wait #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait (
    .clk    (clk),
    .rst    (rst),
    .req_i  (w_req),
    .ack_i  (w_ack),
    .err_i  (w_err),
    .done_o (w_done),
    .fail_o (w_fail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StFetch;
      r_stat      <= STAT_AOK;
      r_icode     <= ICODE_NOP;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != StStop) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      case (r_state)
        StFetch: begin
          if (w_done) begin
            r_state <= StDecode;
          end else if (w_fail) begin
            r_stat  <= STAT_ADR;
            r_state <= StStop;
          end
        end
        StDecode: begin
          r_icode <= icode_i;
          if (!icode_valid(icode_i)) begin
            r_stat  <= STAT_INS;
            r_state <= StStop;
          end else if (icode_i == ICODE_HALT) begin
            r_stat  <= STAT_HLT;
            r_state <= StStop;
          end else begin
            r_state <= StExecute;
          end
        end
        StExecute: r_state <= StMemory;
        StMemory: begin
          if (!w_mem_op || w_done) begin
            r_state <= StWriteback;
          end else if (w_fail) begin
            r_stat  <= STAT_ADR;
            r_state <= StStop;
          end
        end
        StWriteback: r_state <= StPcupd;
        StPcupd: begin
          r_instr_cnt <= r_instr_cnt + CNT_W'(1);
          r_state     <= StFetch;
        end
        StStop:  r_state <= StStop;
        default: r_state <= StStop;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl (TIMEOUT = 4): stage walk, delayed/absent acks, HLT/INS/ADR stops, resets.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode_i;
  logic        imem_req_o, imem_ack_i, imem_err_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i, dmem_err_i;
  logic        f_en_o, d_en_o, e_en_o, m_en_o, w_en_o, pc_en_o;
  logic [2:0]  stat_o, state_o;
  logic [31:0] cycle_cnt_o, instr_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .icode_i     (icode_i),
    .imem_req_o  (imem_req_o),
    .imem_ack_i  (imem_ack_i),
    .imem_err_i  (imem_err_i),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_ack_i  (dmem_ack_i),
    .dmem_err_i  (dmem_err_i),
    .f_en_o      (f_en_o),
    .d_en_o      (d_en_o),
    .e_en_o      (e_en_o),
    .m_en_o      (m_en_o),
    .w_en_o      (w_en_o),
    .pc_en_o     (pc_en_o),
    .stat_o      (stat_o),
    .state_o     (state_o),
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // From FETCH: immediate clean fetch ack, then present icode in DECODE and step past it.
  task automatic fetch_decode(input logic [3:0] code);
    imem_ack_i = 1'b1;
    #1;
    check("fetch_f_en", 32'(f_en_o), 32'd1);
    tick();
    imem_ack_i = 1'b0;
    icode_i    = code;
    #1;
    check("decode_d_en", 32'(d_en_o), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; icode_i = 4'h1;
    imem_ack_i = 1'b0; imem_err_i = 1'b0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_stat", 32'(stat_o), 32'd1);
    check("rst_imem_req", 32'(imem_req_o), 32'd1);
    check("rst_f_en", 32'(f_en_o), 32'd0);
    check("rst_dmem_req", 32'(dmem_req_o), 32'd0);
    check("rst_cycle", cycle_cnt_o, 32'd0);
    check("rst_instr", instr_cnt_o, 32'd0);

    // NOP walks every stage once.
    fetch_decode(4'h1);
    check("nop_exec_state", 32'(state_o), 32'd2);
    check("nop_e_en", 32'(e_en_o), 32'd1);
    tick();
    check("nop_mem_state", 32'(state_o), 32'd3);
    check("nop_m_en", 32'(m_en_o), 32'd1);
    check("nop_no_dreq", 32'(dmem_req_o), 32'd0);
    tick();
    check("nop_w_en", 32'(w_en_o), 32'd1);
    tick();
    check("nop_pc_en", 32'(pc_en_o), 32'd1);
    check("nop_instr_pre", instr_cnt_o, 32'd0);
    tick();
    check("nop_back_fetch", 32'(state_o), 32'd0);
    check("nop_instr", instr_cnt_o, 32'd1);
    check("nop_cycle", cycle_cnt_o, 32'd6);

    // PUSHL with the data ack in the 4th request cycle (also the timeout limit cycle).
    fetch_decode(4'hA);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ack_i = (i == 3);
      #1;
      check("push_dreq", 32'(dmem_req_o), 32'd1);
      check("push_we", 32'(dmem_we_o), 32'd1);
      check("push_m_en", 32'(m_en_o), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_ack_i = 1'b0;
    check("push_wb_state", 32'(state_o), 32'd4);
    check("push_dreq_off", 32'(dmem_req_o), 32'd0);
    tick();
    tick();
    check("push_instr", instr_cnt_o, 32'd2);
    check("push_cycle", cycle_cnt_o, 32'd15);

    // MRMOVL with no data ack: ADR after 4 request cycles.
    fetch_decode(4'h5);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("mr_to_state", 32'(state_o), 32'd3);
      check("mr_to_we", 32'(dmem_we_o), 32'd0);
      check("mr_to_m_en", 32'(m_en_o), 32'd0);
      tick();
    end
    check("mr_to_stop", 32'(state_o), 32'd6);
    check("mr_to_stat", 32'(stat_o), 32'd3);
    check("mr_to_cycle", cycle_cnt_o, 32'd22);
    tick();
    check("mr_to_frozen", cycle_cnt_o, 32'd22);
    check("stop_no_dreq", 32'(dmem_req_o), 32'd0);
    do_reset();
    #1;
    check("rst2_stat", 32'(stat_o), 32'd1);
    check("rst2_cycle", cycle_cnt_o, 32'd0);

    // MRMOVL with ack in the 4th request cycle completes.
    fetch_decode(4'h5);
    tick();
    tick();
    tick();
    tick();
    dmem_ack_i = 1'b1;
    #1;
    check("mr_late_m_en", 32'(m_en_o), 32'd1);
    tick();
    dmem_ack_i = 1'b0;
    check("mr_late_wb", 32'(state_o), 32'd4);
    tick();
    tick();
    check("mr_late_instr", instr_cnt_o, 32'd1);
    check("mr_late_cycle", cycle_cnt_o, 32'd9);
    check("mr_late_stat", 32'(stat_o), 32'd1);

    // Invalid icode 0xC.
    fetch_decode(4'hC);
    check("ins_state", 32'(state_o), 32'd6);
    check("ins_stat", 32'(stat_o), 32'd4);
    check("ins_e_en", 32'(e_en_o), 32'd0);
    check("ins_pc_en", 32'(pc_en_o), 32'd0);
    tick();
    check("ins_cycle", cycle_cnt_o, 32'd11);
    check("ins_instr", instr_cnt_o, 32'd1);
    do_reset();

    // HALT, then reset out of STOP.
    fetch_decode(4'h0);
    check("hlt_state", 32'(state_o), 32'd6);
    check("hlt_stat", 32'(stat_o), 32'd2);
    tick();
    check("hlt_pc_en", 32'(pc_en_o), 32'd0);
    check("hlt_imem_req", 32'(imem_req_o), 32'd0);
    do_reset();
    #1;
    check("hlt_rst_stat", 32'(stat_o), 32'd1);
    check("hlt_rst_state", 32'(state_o), 32'd0);
    check("hlt_rst_imem_req", 32'(imem_req_o), 32'd1);

    // Instruction address error.
    imem_ack_i = 1'b1;
    imem_err_i = 1'b1;
    #1;
    check("ierr_f_en", 32'(f_en_o), 32'd0);
    tick();
    imem_ack_i = 1'b0;
    imem_err_i = 1'b0;
    check("ierr_state", 32'(state_o), 32'd6);
    check("ierr_stat", 32'(stat_o), 32'd3);
    do_reset();

    // Reset in the middle of a data wait.
    fetch_decode(4'hA);
    tick();
    tick();
    check("mid_dreq", 32'(dmem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_state", 32'(state_o), 32'd0);
    check("mid_dreq_off", 32'(dmem_req_o), 32'd0);
    check("mid_cycle", cycle_cnt_o, 32'd0);
    check("mid_instr", instr_cnt_o, 32'd0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
